spi_burst_deserializer: RTL and testbench

Parametrised successor to the single-word SPI deserializer in the IMU front end. It receives one complete SPI read burst on spi_miso: an optional command/address phase, then NUM_WORDS consecutive data words (for example accel X/Y/Z and gyro X/Y/Z).
- Each word is emitted as it completes: a parallel, byte-reordered output with a word index and a one-cycle valid strobe.
- End-of-burst and aborted-burst status feed the downstream filter input stage.

---
 rtl/spi_burst_deserializer.sv | 143 ++++++++++++++
 tb/tb_spi_burst_deserializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_deserializer.sv
// SPI read-burst deserializer: discards a command/address preamble, then emits
// NUM_WORDS byte-reordered words with index and strobes, flagging aborted bursts.
module spi_burst_deserializer #(
  parameter  int WORD_W     = 16,
  parameter  int NUM_WORDS  = 6,
  parameter  int SKIP_BITS  = 8,
  parameter  bit SWAP_BYTES = 1'b1,
  localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              spi_sck,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_miso,
  output logic [WORD_W-1:0] word_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  output logic              burst_done,
  output logic              frame_error
);

  localparam int NB    = WORD_W / 8;
  localparam int BIT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [5:0]        skip_cnt_q, skip_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_out_q, word_out_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic              word_valid_q, word_valid_d;
  logic              burst_done_q, burst_done_d;
  logic              frame_error_q, frame_error_d;
  logic [WORD_W-1:0] shift_full;
  logic              capture;

  // The first received byte sits in the top bits of the shift register.
  function automatic logic [WORD_W-1:0] reorder(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    if (SWAP_BYTES) begin
      for (int i = 0; i < NB; i++) r[8*i +: 8] = w[WORD_W-1-8*i -: 8];
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    shift_d       = shift_q;
    word_out_d    = word_out_q;
    word_idx_d    = word_idx_q;
    word_valid_d  = 1'b0;
    burst_done_d  = 1'b0;
    frame_error_d = frame_error_q;
    shift_full    = {shift_q[WORD_W-2:0], spi_miso};
    capture       = 1'b0;

    if (spi_cs) begin
      state_d    = IDLE;
      skip_cnt_d = '0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      if (state_q == SKIP || state_q == SHIFT) frame_error_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (SKIP_BITS == 0) begin
            capture = 1'b1;
            state_d = SHIFT;
          end else begin
            skip_cnt_d = 6'd1;
            state_d    = (SKIP_BITS == 1) ? SHIFT : SKIP;
          end
        end
        SKIP: begin
          skip_cnt_d = skip_cnt_q + 6'd1;
          if (skip_cnt_q == 6'(SKIP_BITS - 1)) state_d = SHIFT;
        end
        SHIFT:   capture = 1'b1;
        DONE:    ;
        default: state_d = IDLE;
      endcase

      // Counters are zero on leaving IDLE, so edge 0 can share this path.
      if (capture) begin
        shift_d   = shift_full;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
          bit_cnt_d    = '0;
          word_out_d   = reorder(shift_full);
          word_idx_d   = word_cnt_q;
          word_valid_d = 1'b1;
          word_cnt_d   = word_cnt_q + 1'b1;
          if (word_cnt_q == IDX_W'(NUM_WORDS - 1)) begin
            burst_done_d  = 1'b1;
            frame_error_d = 1'b0;
            state_d       = DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge spi_sck) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q       <= IDLE;
      skip_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      shift_q       <= '0;
      word_out_q    <= '0;
      word_idx_q    <= '0;
      word_valid_q  <= 1'b0;
      burst_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      shift_q       <= shift_d;
      word_out_q    <= word_out_d;
      word_idx_q    <= word_idx_d;
      word_valid_q  <= word_valid_d;
      burst_done_q  <= burst_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign word_out    = word_out_q;
  assign word_idx    = word_idx_q;
  assign word_valid  = word_valid_q;
  assign burst_done  = burst_done_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_burst_deserializer.sv
// Bench for spi_burst_deserializer: three configurations checked every cycle
// against a bit-index model, plus hand-computed burst expectations.
module tb_spi_burst_deserializer;

  logic spi_sck = 1'b0;
  logic rst_n, cs_a, miso_a, cs_c, miso_c;

  logic [15:0] wo_a, wo_b;
  logic [1:0]  idx_a, idx_b;
  logic        wv_a, bd_a, fe_a, wv_b, bd_b, fe_b;
  logic [31:0] wo_c;
  logic [0:0]  idx_c;
  logic        wv_c, bd_c, fe_c;

  int n_vec = 0;
  int n_err = 0;

  spi_burst_deserializer #(.WORD_W(16), .NUM_WORDS(3), .SKIP_BITS(8), .SWAP_BYTES(1'b1)) dut_a (
    .spi_sck(spi_sck), .rst_n(rst_n), .spi_cs(cs_a), .spi_miso(miso_a),
    .word_out(wo_a), .word_idx(idx_a), .word_valid(wv_a), .burst_done(bd_a), .frame_error(fe_a));

  spi_burst_deserializer #(.WORD_W(16), .NUM_WORDS(3), .SKIP_BITS(8), .SWAP_BYTES(1'b0)) dut_b (
    .spi_sck(spi_sck), .rst_n(rst_n), .spi_cs(cs_a), .spi_miso(miso_a),
    .word_out(wo_b), .word_idx(idx_b), .word_valid(wv_b), .burst_done(bd_b), .frame_error(fe_b));

  spi_burst_deserializer #(.WORD_W(32), .NUM_WORDS(1), .SKIP_BITS(0), .SWAP_BYTES(1'b1)) dut_c (
    .spi_sck(spi_sck), .rst_n(rst_n), .spi_cs(cs_c), .spi_miso(miso_c),
    .word_out(wo_c), .word_idx(idx_c), .word_valid(wv_c), .burst_done(bd_c), .frame_error(fe_c));

  always #5 spi_sck = ~spi_sck;

  // Model: bits are recorded by edge number since CS fell; words are cut out by index.
  int P_W[3]  = '{16, 16, 32};
  int P_NW[3] = '{3, 3, 1};
  int P_SK[3] = '{8, 8, 0};
  bit P_SW[3] = '{1'b1, 1'b0, 1'b1};

  int           m_n[3];
  bit           m_done[3];
  logic [511:0] m_bits[3];
  logic [31:0]  m_wo[3];
  int           m_idx[3];
  bit           m_wv[3], m_bd[3], m_fe[3];
  bit           model_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int d, input logic rst, input logic cs, input logic mi);
    int k, base;
    logic [31:0] v;
    logic [7:0] byt;
    if (!rst) begin
      m_n[d] = 0; m_done[d] = 0; m_wo[d] = 0; m_idx[d] = 0;
      m_wv[d] = 0; m_bd[d] = 0; m_fe[d] = 0;
    end else if (cs) begin
      m_wv[d] = 0; m_bd[d] = 0;
      if (m_n[d] > 0 && !m_done[d]) m_fe[d] = 1;
      m_n[d] = 0; m_done[d] = 0;
    end else begin
      m_wv[d] = 0; m_bd[d] = 0;
      if (!m_done[d]) begin
        m_bits[d][m_n[d]] = mi;
        if (m_n[d] >= P_SK[d] && (m_n[d] - P_SK[d]) % P_W[d] == P_W[d] - 1) begin
          k    = (m_n[d] - P_SK[d]) / P_W[d];
          base = P_SK[d] + k * P_W[d];
          v    = 0;
          for (int i = 0; i < P_W[d] / 8; i++) begin
            for (int j = 0; j < 8; j++) byt[7-j] = m_bits[d][base + 8*i + j];
            if (P_SW[d]) v |= 32'(byt) << (8*i);
            else         v |= 32'(byt) << (P_W[d] - 8 - 8*i);
          end
          m_wo[d] = v; m_idx[d] = k; m_wv[d] = 1;
          if (k == P_NW[d] - 1) begin
            m_bd[d] = 1; m_fe[d] = 0; m_done[d] = 1;
          end
        end
        m_n[d]++;
      end
    end
  endtask

  always @(posedge spi_sck) begin
    model_step(0, rst_n, cs_a, miso_a);
    model_step(1, rst_n, cs_a, miso_a);
    model_step(2, rst_n, cs_c, miso_c);
    model_ready = 1'b1;
  end

  task automatic cmp_dut(input int d, input logic [31:0] wo, input logic [31:0] idx,
                         input logic wv, input logic bd, input logic fe);
    string p;
    p = $sformatf("dut%0d", d);
    check({p, ".word_out"},    wo,  m_wo[d]);
    check({p, ".word_idx"},    idx, 32'(m_idx[d]));
    check({p, ".word_valid"},  32'(wv), 32'(m_wv[d]));
    check({p, ".burst_done"},  32'(bd), 32'(m_bd[d]));
    check({p, ".frame_error"}, 32'(fe), 32'(m_fe[d]));
  endtask

  always @(negedge spi_sck) begin
    if (model_ready) begin
      cmp_dut(0, 32'(wo_a), 32'(idx_a), wv_a, bd_a, fe_a);
      cmp_dut(1, 32'(wo_b), 32'(idx_b), wv_b, bd_b, fe_b);
      cmp_dut(2, wo_c, 32'(idx_c), wv_c, bd_c, fe_c);
    end
  end

  task automatic tick();
    @(posedge spi_sck);
    #2;
  endtask

  task automatic send_byte_a(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      cs_a = 1'b0; miso_a = b[i]; tick();
    end
  endtask

  task automatic send_byte_c(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      cs_c = 1'b0; miso_c = b[i]; tick();
    end
  endtask

  task automatic rand_edges_a(input int n);
    repeat (n) begin
      cs_a = 1'b0; miso_a = 1'($urandom); tick();
      check("no_strobe_partial", 32'(wv_a), 32'd0);
    end
  endtask

  task automatic idle_a(input int n);
    cs_a = 1'b1; miso_a = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_a, run_c;
    rst_n = 1'b0; cs_a = 1'b1; miso_a = 1'b0; cs_c = 1'b1; miso_c = 1'b0;
    tick(); tick();
    check("rst_word_out", 32'(wo_a), 32'd0);
    check("rst_word_idx", 32'(idx_a), 32'd0);
    check("rst_valid", 32'(wv_a), 32'd0);
    check("rst_done", 32'(bd_a), 32'd0);
    check("rst_ferr", 32'(fe_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reference burst: A5 | 34 12 | CD AB | 00 80
    send_byte_a(8'hA5);
    send_byte_a(8'h34);
    check("t1_no_valid_mid", 32'(wv_a), 32'd0);
    send_byte_a(8'h12);
    check("t1_w0_valid", 32'(wv_a), 32'd1);
    check("t1_w0_idx", 32'(idx_a), 32'd0);
    check("t1_w0_swap", 32'(wo_a), 32'h1234);
    check("t2_w0_noswap", 32'(wo_b), 32'h3412);
    send_byte_a(8'hCD);
    send_byte_a(8'hAB);
    check("t1_w1_swap", 32'(wo_a), 32'hABCD);
    check("t2_w1_noswap", 32'(wo_b), 32'hCDAB);
    check("t1_w1_idx", 32'(idx_a), 32'd1);
    check("t1_w1_not_done", 32'(bd_a), 32'd0);
    send_byte_a(8'h00);
    send_byte_a(8'h80);
    check("t1_w2_swap", 32'(wo_a), 32'h8000);
    check("t2_w2_noswap", 32'(wo_b), 32'h0080);
    check("t1_w2_idx", 32'(idx_a), 32'd2);
    check("t1_w2_valid", 32'(wv_a), 32'd1);
    check("t1_burst_done", 32'(bd_a), 32'd1);
    check("t1_ferr", 32'(fe_a), 32'd0);

    // Overrun after completion
    repeat (16) begin
      cs_a = 1'b0; miso_a = 1'($urandom); tick();
      check("t4_no_valid", 32'(wv_a), 32'd0);
      check("t4_no_done", 32'(bd_a), 32'd0);
    end
    check("t4_hold_word", 32'(wo_a), 32'h8000);
    check("t4_hold_idx", 32'(idx_a), 32'd2);
    idle_a(1);
    check("t4_cs_from_done_ferr", 32'(fe_a), 32'd0);

    // Abort after 20 edges
    rand_edges_a(20);
    idle_a(1);
    check("t3_abort_ferr", 32'(fe_a), 32'd1);
    check("t3_abort_valid", 32'(wv_a), 32'd0);

    // Reset at edge 30 of a burst; word 0 was emitted at edge 23 before it
    repeat (30) begin
      cs_a = 1'b0; miso_a = 1'($urandom); tick();
    end
    rst_n = 1'b0; cs_a = 1'b0; tick();
    check("t5_rst_word_out", 32'(wo_a), 32'd0);
    check("t5_rst_idx", 32'(idx_a), 32'd0);
    check("t5_rst_ferr", 32'(fe_a), 32'd0);
    check("t5_rst_valid", 32'(wv_a), 32'd0);
    rst_n = 1'b1;
    send_byte_a(8'hA5);
    send_byte_a(8'h11); send_byte_a(8'h22);
    check("t5_w0", 32'(wo_a), 32'h2211);
    check("t5_w0_idx", 32'(idx_a), 32'd0);
    send_byte_a(8'h33); send_byte_a(8'h44);
    check("t5_w1", 32'(wo_a), 32'h4433);
    check("t5_w1_idx", 32'(idx_a), 32'd1);
    send_byte_a(8'h55); send_byte_a(8'h66);
    check("t5_w2", 32'(wo_a), 32'h6655);
    check("t5_w2_idx", 32'(idx_a), 32'd2);
    check("t5_done", 32'(bd_a), 32'd1);

    // Abort, then a full burst clears frame_error only at burst_done
    idle_a(1);
    rand_edges_a(20);
    idle_a(1);
    check("t3b_abort_ferr", 32'(fe_a), 32'd1);
    send_byte_a(8'h00);
    send_byte_a(8'h01); send_byte_a(8'h02);
    check("t3b_ferr_held", 32'(fe_a), 32'd1);
    check("t3b_w0", 32'(wo_a), 32'h0201);
    send_byte_a(8'h03); send_byte_a(8'h04);
    send_byte_a(8'h05); send_byte_a(8'h06);
    check("t3b_done", 32'(bd_a), 32'd1);
    check("t3b_ferr_cleared", 32'(fe_a), 32'd0);
    idle_a(2);

    // 32-bit single word, no preamble
    send_byte_c(8'h78); send_byte_c(8'h56); send_byte_c(8'h34);
    check("t6_no_valid_early", 32'(wv_c), 32'd0);
    send_byte_c(8'h12);
    check("t6_valid", 32'(wv_c), 32'd1);
    check("t6_done", 32'(bd_c), 32'd1);
    check("t6_word", wo_c, 32'h12345678);
    check("t6_idx", 32'(idx_c), 32'd0);
    cs_c = 1'b1; tick();

    // Random bursts, aborts and resets on both channels
    run_a = 0; run_c = 0;
    repeat (3000) begin
      if (run_a <= 0) begin
        cs_a  = ~cs_a;
        run_a = cs_a ? $urandom_range(1, 3) : $urandom_range(1, 70);
      end
      if (run_c <= 0) begin
        cs_c  = ~cs_c;
        run_c = cs_c ? $urandom_range(1, 3) : $urandom_range(1, 40);
      end
      miso_a = 1'($urandom);
      miso_c = 1'($urandom);
      rst_n  = ($urandom_range(0, 199) != 0);
      run_a--; run_c--;
      tick();
    end
    rst_n = 1'b1; cs_a = 1'b1; cs_c = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
